// File: rtl/spi_responder_pkg.sv
// Shared definitions for the SPI mode-0 responder.
//   state_e           : frame FSM encoding (IDLE / ACTIVE).
//   FILL_BYTE_DEFAULT : byte shifted out on MISO when nothing is buffered.
package spi_responder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_responder_shift.sv
// Receive/transmit shift registers and bit counter of the SPI responder.
//   clk_i, rst_i  : system clock, asynchronous active-high reset
//   start_i       : frame start, clears the bit counter
//   rise_i        : qualified SCK rising-edge pulse (sample MOSI)
//   fall_i        : qualified SCK falling-edge pulse (advance MISO)
//   sdi_i         : synchronized MOSI
//   load_i        : load load_data_i into the transmit shifter
//   load_data_i   : next transmit byte (buffered byte or fill byte)
//   byte_done_o   : combinational, this rise completes a byte
//   bit_cnt_o     : bits received in the current byte
//   tx_msb_o      : current MISO bit
//   rx_data_o     : last completed receive byte
//   rx_valid_o    : one-cycle pulse with each completed byte
module spi_responder_shift (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rise_i,
  input  logic       fall_i,
  input  logic       sdi_i,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  output logic       byte_done_o,
  output logic [2:0] bit_cnt_o,
  output logic       tx_msb_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);

  logic [2:0] bit_cnt_q;
  logic [7:0] rx_shift_q;
  logic [7:0] tx_shift_q;

  assign byte_done_o = rise_i && (bit_cnt_q == 3'd7);
  assign bit_cnt_o   = bit_cnt_q;
  assign tx_msb_o    = tx_shift_q[7];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (start_i) begin
        // A partial byte from an aborted frame is dropped here; its stale
        // bits in rx_shift_q are pushed out by the next eight samples.
        bit_cnt_q <= 3'd0;
      end else if (rise_i) begin
        rx_shift_q <= {rx_shift_q[6:0], sdi_i};
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_data_o  <= {rx_shift_q[6:0], sdi_i};
          rx_valid_o <= 1'b1;
        end
      end
    end
  end

  // The fall that follows the 8th rise sees bit_cnt == 0 and is ignored,
  // so the MSB of the freshly loaded byte stays on MISO for the next rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_shift_q <= 8'h00;
    end else if (load_i) begin
      tx_shift_q <= load_data_i;
    end else if (fall_i && (bit_cnt_q != 3'd0)) begin
      tx_shift_q <= {tx_shift_q[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_responder_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous input bit.
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   d_i          : asynchronous input
//   q_o          : input resynchronized to clk_i (Stages cycles of latency)
// ResetValue sets the level the chain holds during reset, so the
// downstream logic sees the pin's idle level and no spurious edge.
module spi_responder_sync #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= {Stages{ResetValue}};
    end else begin
      chain_q <= {chain_q[Stages-2:0], d_i};
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder (single data lane), system-clock oversampled.
//   clk_i, rst_i         : system clock, asynchronous active-high reset
//   spi_sck_i/csb_i/sdi_i: asynchronous SPI pins from the host
//   spi_sdo_o            : MISO, 0 outside a frame
//   spi_sdo_en_o         : MISO output enable (high during a frame)
//   rx_data_o/rx_valid_o : received byte and its one-cycle pulse
//   tx_data_i/tx_valid_i/tx_ready_o : one-entry transmit buffer write port
//   tx_underrun_o        : pulse when the fill byte is loaded
//   frame_abort_o        : pulse when CSB rises mid-byte
//   active_o             : frame in progress (FSM state == ACTIVE)
//
// tx handshake: a byte is accepted on every clk_i edge where tx_valid_i
// and tx_ready_o are both high; tx_ready_o is high exactly when the buffer
// is empty and does not depend on tx_valid_i.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter logic [7:0]  FillByte   = FILL_BYTE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sck_i,
  input  logic       spi_csb_i,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_en_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       frame_abort_o,
  output logic       active_o
);

  logic   sck_s, csb_s, sdi_s;
  logic   sck_q;
  logic   sck_rise, sck_fall;
  state_e state_q, state_d;
  logic   frame_start, frame_stop;
  logic   rise_en, fall_en;
  logic   byte_done, load;
  logic [2:0] bit_cnt;
  logic [7:0] load_data;
  logic   tx_msb;
  logic   buf_valid_q;
  logic [7:0] buf_data_q;
  logic   underrun_q, abort_q;

  spi_responder_sync #(.Stages(SyncStages), .ResetValue(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sck_i), .q_o(sck_s)
  );
  spi_responder_sync #(.Stages(SyncStages), .ResetValue(1'b1)) u_sync_csb (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_csb_i), .q_o(csb_s)
  );
  spi_responder_sync #(.Stages(SyncStages), .ResetValue(1'b0)) u_sync_sdi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(spi_sdi_i), .q_o(sdi_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sck_q <= 1'b0;
    else       sck_q <= sck_s;
  end

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!csb_s) begin
          state_d     = ST_ACTIVE;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (csb_s) begin
          state_d    = ST_IDLE;
          frame_stop = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // CSB deassertion wins over an SCK edge seen in the same cycle.
  assign rise_en = (state_q == ST_ACTIVE) && !csb_s && sck_rise;
  assign fall_en = (state_q == ST_ACTIVE) && !csb_s && sck_fall;

  assign load      = frame_start | byte_done;
  assign load_data = buf_valid_q ? buf_data_q : FillByte;

  spi_responder_shift u_shift (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (frame_start),
    .rise_i      (rise_en),
    .fall_i      (fall_en),
    .sdi_i       (sdi_s),
    .load_i      (load),
    .load_data_i (load_data),
    .byte_done_o (byte_done),
    .bit_cnt_o   (bit_cnt),
    .tx_msb_o    (tx_msb),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o)
  );

  // No bypass: a write landing in the same cycle as a load from an empty
  // buffer is kept for the next load while the fill byte goes out now.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= 8'h00;
    end else begin
      if (load && buf_valid_q) begin
        buf_valid_q <= 1'b0;
      end
      if (tx_valid_i && !buf_valid_q) begin
        buf_valid_q <= 1'b1;
        buf_data_q  <= tx_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      underrun_q <= load && !buf_valid_q;
      abort_q    <= frame_stop && (bit_cnt != 3'd0);
    end
  end

  assign tx_ready_o    = ~buf_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_abort_o = abort_q;
  assign active_o      = (state_q == ST_ACTIVE);
  assign spi_sdo_en_o  = active_o;
  assign spi_sdo_o     = active_o & tx_msb;

endmodule
